// File: rtl/aes_block_loader.sv
// aes_block_loader
// ----------------
// Upstream feeder for the AES cipher core. Collects a byte stream and packs
// 16 bytes into one 128-bit state block in AES byte order (first byte in
// [127:120], sixteenth in [7:0]). Each block is offered to the cipher on a
// valid/ready output. The final block of a message is flagged, and a short
// trailing block is completed with filler bytes.
//
// Build option:
//   AES_PKCS7_PAD_EN  When defined, a short final block is completed with
//                     PKCS#7 padding. A message that ends exactly on a block
//                     boundary is followed by an extra block of 16 x 8'h10.
//                     When undefined, unused slots take FILL_BYTE and there
//                     is no pad block.
//
// Handshakes: a transfer occurs on a rising clk edge where valid and ready
// are both high. Once valid is raised, data must stay stable until that
// transfer. byte_ready is driven only in FILL, and block_valid only in HOLD
// or PAD, so the two sides never transfer in the same cycle. This gives one
// bubble cycle per block.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   byte_in      stream data byte
//   byte_valid   byte_in valid
//   byte_last    byte_in is the final byte of its message
//   byte_ready   loader can accept a byte this cycle
//   block_out    packed 128-bit block
//   block_valid  block_out valid
//   block_ready  cipher accepts the block this cycle
//   block_last   block_out is the final block of its message
//   block_bytes  message bytes carried in block_out (1..16)
//
// FSM state is held in the `state` signal (state_t) for checker binding.
module aes_block_loader #(
    parameter logic [7:0] FILL_BYTE   = 8'h00,
    parameter int         BLOCK_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic [127:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last,
    output logic [4:0]   block_bytes
);

    generate
        if (BLOCK_BYTES != 16) begin : g_bad_block_bytes
            $error("aes_block_loader: BLOCK_BYTES must be 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HOLD = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   idx;
    logic [127:0] block_q;
    logic [4:0]   bytes_q;
    logic         last_q;
    logic         pad_pending;   // a pad-only block must follow the held block

    logic         byte_xfer;
    logic         block_xfer;
    logic         closing;
    logic [7:0]   fill_val;
    logic         close_last;
    logic [4:0]   close_bytes;
    logic         close_pad;
    logic [127:0] packed_next;

    assign byte_xfer  = byte_valid & byte_ready;
    assign block_xfer = block_valid & block_ready;
    assign closing    = byte_last | (idx == 4'd15);

`ifdef AES_PKCS7_PAD_EN
    // The closing byte sits at idx, so n = idx+1 and the pad value is 16-n = 15-idx.
    assign fill_val    = {4'h0, 4'd15 - idx};
    assign close_bytes = 5'd16;
    // A message ending on a block boundary still needs its pad block, so
    // that data block is not the last one.
    assign close_last  = byte_last & (idx != 4'd15);
    assign close_pad   = byte_last & (idx == 4'd15);
`else
    assign fill_val    = FILL_BYTE;
    assign close_bytes = {1'b0, idx} + 5'd1;
    assign close_last  = byte_last;
    assign close_pad   = 1'b0;
`endif

    // Block contents after accepting byte_in at slot idx. On a closing byte,
    // every slot after idx also receives the filler value.
    always_comb begin
        packed_next = block_q;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == idx)
                packed_next[127-8*i -: 8] = byte_in;
            else if (closing && (4'(i) > idx))
                packed_next[127-8*i -: 8] = fill_val;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FILL:  if (byte_xfer && closing) state_next = S_HOLD;
            S_HOLD:  if (block_ready) state_next = pad_pending ? S_PAD : S_FILL;
            S_PAD:   if (block_ready) state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    // Output logic. byte_ready is masked by rst so that it stays low for the
    // whole reset, even though the reset state is FILL.
    always_comb begin
        byte_ready  = 1'b0;
        block_valid = 1'b0;
        case (state)
            S_FILL:       byte_ready  = ~rst;
            S_HOLD, S_PAD: block_valid = 1'b1;
            default:      ;
        endcase
    end

    // Datapath. A byte transfer and a block transfer never occur in the same
    // cycle, because ready and valid come from different states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= 4'd0;
            block_q     <= 128'h0;
            bytes_q     <= 5'd0;
            last_q      <= 1'b0;
            pad_pending <= 1'b0;
        end else if (byte_xfer) begin
            block_q <= packed_next;
            if (closing) begin
                idx         <= 4'd0;
                bytes_q     <= close_bytes;
                last_q      <= close_last;
                pad_pending <= close_pad;
            end else begin
                idx <= idx + 4'd1;
            end
        end else if (block_xfer) begin
            if (pad_pending) begin
                block_q     <= {16{8'h10}};
                bytes_q     <= 5'd16;
                last_q      <= 1'b1;
                pad_pending <= 1'b0;
            end else begin
                block_q <= 128'h0;
                bytes_q <= 5'd0;
                last_q  <= 1'b0;
            end
        end
    end

    assign block_out   = block_q;
    assign block_bytes = bytes_q;
    assign block_last  = last_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Testbench for aes_block_loader. Stimulus is issued by driver tasks, which
// push the expected blocks, computed from whole messages, into a queue. A
// separate monitor pops and compares each block the DUT hands off.
module tb_aes_block_loader;

    localparam logic [7:0] TB_FILL = 8'h00;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;
    logic [4:0]   block_bytes;

    int n_vec = 0;
    int n_err = 0;
    int last_seen = 0;
    bit rand_ready = 1'b0;

    logic [127:0] exp_q[$];
    logic [4:0]   exp_bytes_q[$];
    logic         exp_last_q[$];

    aes_block_loader #(.FILL_BYTE(TB_FILL), .BLOCK_BYTES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last),
        .block_bytes (block_bytes)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Splits a whole message into 16-byte chunks and derives each block from
    // the message bytes directly.
    task automatic model_msg(input logic [7:0] msg[$]);
        int n;
        int pos;
        int cnt;
        bit fin;
        logic [7:0]   fillv;
        logic [127:0] blk;
        n = msg.size();
        pos = 0;
        while (pos < n) begin
            cnt = (n - pos >= 16) ? 16 : n - pos;
            fin = (pos + cnt == n);
`ifdef AES_PKCS7_PAD_EN
            fillv = 8'(16 - cnt);
`else
            fillv = TB_FILL;
`endif
            for (int k = 0; k < 16; k++)
                blk[127-8*k -: 8] = (k < cnt) ? msg[pos+k] : fillv;
            exp_q.push_back(blk);
`ifdef AES_PKCS7_PAD_EN
            exp_bytes_q.push_back(5'd16);
            exp_last_q.push_back(fin && cnt < 16);
            if (fin && cnt == 16) begin
                exp_q.push_back({16{8'h10}});
                exp_bytes_q.push_back(5'd16);
                exp_last_q.push_back(1'b1);
            end
`else
            exp_bytes_q.push_back(5'(cnt));
            exp_last_q.push_back(fin);
`endif
            pos += cnt;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input logic last, input int max_gap);
        int gap;
        int t;
        gap = int'($urandom_range(0, max_gap));
        repeat (gap) begin @(posedge clk); #1; end
        byte_in = b;
        byte_last = last;
        byte_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            t++;
            if (t > 400) begin
                check("byte_accept_timeout", 128'(byte_ready), 128'd1);
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input int max_gap);
        model_msg(msg);
        for (int k = 0; k < msg.size(); k++)
            send_byte(msg[k], k == msg.size() - 1, max_gap);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 128'(byte_ready), 128'd0);
        check({tag, "_block_valid"}, 128'(block_valid), 128'd0);
        check({tag, "_block_last"}, 128'(block_last), 128'd0);
        check({tag, "_block_out"}, block_out, 128'h0);
        check({tag, "_block_bytes"}, 128'(block_bytes), 128'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && block_valid && block_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_block", 128'(block_valid), 128'd0);
            end else begin
                check("block_out", block_out, exp_q.pop_front());
                check("block_bytes", 128'(block_bytes), 128'(exp_bytes_q.pop_front()));
                check("block_last", 128'(block_last), 128'(exp_last_q.pop_front()));
                if (block_last) last_seen++;
            end
        end
    end

    // Randomized cipher back-pressure, enabled per test.
    always @(posedge clk) begin
        #1;
        if (rand_ready) block_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0]   m[$];
        logic [127:0] snap;
        int t;
        int len;

        rst = 1'b1;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        block_ready = 1'b0;

        // Outputs held at reset values while rst is asserted.
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_reset_byte_ready", 128'(byte_ready), 128'd1);

        // Test 1: bytes 00..0F back-to-back, then a closing byte 10.
        block_ready = 1'b1;
        m = {};
        for (int k = 0; k < 16; k++) m.push_back(8'(k));
        m.push_back(8'h10);
        model_msg(m);
        for (int k = 0; k < 15; k++) send_byte(m[k], 1'b0, 0);
        check("t1_no_early_valid", 128'(block_valid), 128'd0);
        send_byte(m[15], 1'b0, 0);
        check("t1_valid_latency", 128'(block_valid), 128'd1);
        check("t1_ready_low", 128'(byte_ready), 128'd0);
        @(posedge clk); #1;
        check("t1_ready_back", 128'(byte_ready), 128'd1);
        check("t1_valid_dropped", 128'(block_valid), 128'd0);
        send_byte(m[16], 1'b1, 0);
        drain("t1_drain");

        // Test 2: short block AA BB CC.
        m = {8'hAA, 8'hBB, 8'hCC};
        send_msg(m, 0);
        drain("t2_drain");

        // Test 3: exactly 16 bytes with last on the 16th.
        m = {};
        for (int k = 0; k < 16; k++) m.push_back(8'($urandom_range(0, 255)));
        send_msg(m, 0);
        drain("t3_drain");

        // Test 4: full block held 5 cycles with a byte pending.
        block_ready = 1'b0;
        m = {};
        for (int k = 0; k < 16; k++) m.push_back(8'($urandom_range(0, 255)));
        m.push_back(8'h5A);
        model_msg(m);
        for (int k = 0; k < 16; k++) send_byte(m[k], 1'b0, 0);
        snap = block_out;
        byte_in = 8'h5A;
        byte_last = 1'b1;
        byte_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_stable", block_out, snap);
            check("t4_hold_byte_ready", 128'(byte_ready), 128'd0);
            check("t4_hold_valid", 128'(block_valid), 128'd1);
        end
        @(posedge clk); #1;
        block_ready = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            t++;
            if (t > 50) begin
                check("t4_accept_timeout", 128'(byte_ready), 128'd1);
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        drain("t4_drain");

        // Test 5: asynchronous reset mid-block after 7 bytes.
        for (int k = 0; k < 7; k++) send_byte(8'($urandom_range(1, 255)), 1'b0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        @(posedge clk); #1;
        rst = 1'b0;
        m = {};
        for (int k = 0; k < 16; k++) m.push_back(8'($urandom_range(0, 255)));
        send_msg(m, 0);
        drain("t5_drain");

        // Test 6: random gaps on both sides over 5 messages.
        last_seen = 0;
        rand_ready = 1'b1;
        for (int mi = 0; mi < 5; mi++) begin
            len = int'($urandom_range(1, 40));
            m = {};
            for (int k = 0; k < len; k++) m.push_back(8'($urandom_range(0, 255)));
            send_msg(m, 2);
        end
        drain("t6_drain");
        rand_ready = 1'b0;
        check("t6_last_count", 128'(last_seen), 128'd5);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
